// File: rtl/mem_line_requester.sv
// Cache-side line-miss controller: optional dirty-line write-back as single-word
// stores, one line-fill read, then a bounded wait for the memory response.
module mem_line_requester #(
    parameter int FILL_DATA_WIDTH  = 128,
    parameter int STORE_DATA_WIDTH = 32,
    parameter int ADDRESS_WIDTH    = 32,
    parameter int TIMEOUT          = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        miss_valid,
    output logic                        miss_ready,
    input  logic [ADDRESS_WIDTH-1:0]    miss_addr,
    input  logic                        evict_valid,
    input  logic [ADDRESS_WIDTH-1:0]    evict_addr,
    input  logic [FILL_DATA_WIDTH-1:0]  evict_line,
    output logic                        fill_valid,
    output logic [FILL_DATA_WIDTH-1:0]  fill_line,
    output logic [ADDRESS_WIDTH-1:0]    fill_addr,
    output logic                        fill_err,
    output logic                        stray_resp,
    output logic                        mem_req,
    output logic                        mem_store,
    output logic [ADDRESS_WIDTH-1:0]    mem_address,
    output logic [STORE_DATA_WIDTH-1:0] mem_evict_data,
    input  logic [FILL_DATA_WIDTH-1:0]  mem_fill_data,
    input  logic                        mem_response_valid
);

    localparam int WPL   = FILL_DATA_WIDTH / STORE_DATA_WIDTH;
    localparam int OFS   = $clog2(WPL);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK = ~ADDRESS_WIDTH'(WPL - 1);
    localparam logic [OFS-1:0]           LAST_WORD = OFS'(WPL - 1);
    localparam logic [CNT_W-1:0]         LAST_WAIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        EVICT,
        FILL_REQ,
        WAIT,
        RESPOND
    } state_t;

    state_t state, state_next;

    logic [OFS-1:0]              word_cnt;
    logic [CNT_W-1:0]            wait_cnt;
    logic [ADDRESS_WIDTH-1:0]    miss_base, evict_base;
    logic [FILL_DATA_WIDTH-1:0]  evict_data;

    logic                        accept;
    logic                        timed_out;
    logic [OFS-1:0]              word_idx_next;
    logic [ADDRESS_WIDTH-1:0]    miss_base_next, evict_base_next;
    logic [FILL_DATA_WIDTH-1:0]  evict_data_next;
    logic                        req_next, store_next;
    logic [ADDRESS_WIDTH-1:0]    addr_next;
    logic [STORE_DATA_WIDTH-1:0] store_word_next;

    assign miss_ready = (state == IDLE);
    assign accept     = miss_valid & miss_ready;
    assign timed_out  = (state == WAIT) && !mem_response_valid && (wait_cnt == LAST_WAIT);

    // Next state plus the values the registered memory-side outputs take on the
    // coming edge, so a request is visible in the same cycle as its state.
    always_comb begin
        state_next      = state;
        miss_base_next  = accept ? (miss_addr & LINE_MASK) : miss_base;
        evict_base_next = accept ? (evict_addr & LINE_MASK) : evict_base;
        evict_data_next = accept ? evict_line : evict_data;
        word_idx_next   = (state == EVICT) ? word_cnt + OFS'(1) : '0;
        store_word_next = '0;

        case (state)
            IDLE:     if (miss_valid) state_next = evict_valid ? EVICT : FILL_REQ;
            EVICT:    if (word_cnt == LAST_WORD) state_next = FILL_REQ;
            FILL_REQ: state_next = WAIT;
            WAIT:     if (mem_response_valid || (wait_cnt == LAST_WAIT)) state_next = RESPOND;
            RESPOND:  state_next = IDLE;
            default:  state_next = IDLE;
        endcase

        req_next   = (state_next == EVICT) || (state_next == FILL_REQ);
        store_next = (state_next == EVICT);
        addr_next  = store_next ? (evict_base_next + ADDRESS_WIDTH'(word_idx_next))
                                : miss_base_next;
        for (int k = 0; k < WPL; k++) begin
            if (word_idx_next == OFS'(k))
                store_word_next = evict_data_next[k*STORE_DATA_WIDTH +: STORE_DATA_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_cnt       <= '0;
            wait_cnt       <= '0;
            miss_base      <= '0;
            evict_base     <= '0;
            evict_data     <= '0;
            mem_req        <= 1'b0;
            mem_store      <= 1'b0;
            mem_address    <= '0;
            mem_evict_data <= '0;
            fill_valid     <= 1'b0;
            fill_line      <= '0;
            fill_addr      <= '0;
            fill_err       <= 1'b0;
            stray_resp     <= 1'b0;
        end else begin
            miss_base  <= miss_base_next;
            evict_base <= evict_base_next;
            evict_data <= evict_data_next;
            word_cnt   <= word_idx_next;
            wait_cnt   <= (state == WAIT) ? wait_cnt + CNT_W'(1) : '0;

            mem_req   <= req_next;
            mem_store <= store_next;
            if (req_next)   mem_address    <= addr_next;
            if (store_next) mem_evict_data <= store_word_next;

            // Response beats a same-cycle timeout.
            fill_valid <= (state_next == RESPOND);
            if ((state == WAIT) && mem_response_valid) begin
                fill_line <= mem_fill_data;
                fill_err  <= 1'b0;
            end else if (timed_out) begin
                fill_line <= '0;
                fill_err  <= 1'b1;
            end
            if (state_next == RESPOND) fill_addr <= miss_base;

            if (mem_response_valid && (state != WAIT)) stray_resp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_line_requester.sv
// Directed bench for mem_line_requester with a word memory model answering
// fill reads MEM_DELAY cycles after the request.
module tb_mem_line_requester;

    localparam int MEM_DELAY = 5;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         miss_valid;
    logic         miss_ready;
    logic [31:0]  miss_addr;
    logic         evict_valid;
    logic [31:0]  evict_addr;
    logic [127:0] evict_line;
    logic         fill_valid;
    logic [127:0] fill_line;
    logic [31:0]  fill_addr;
    logic         fill_err;
    logic         stray_resp;
    logic         mem_req;
    logic         mem_store;
    logic [31:0]  mem_address;
    logic [31:0]  mem_evict_data;
    logic [127:0] mem_fill_data;
    logic         mem_response_valid;

    int tests  = 0;
    int failed = 0;

    mem_line_requester dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .miss_valid         (miss_valid),
        .miss_ready         (miss_ready),
        .miss_addr          (miss_addr),
        .evict_valid        (evict_valid),
        .evict_addr         (evict_addr),
        .evict_line         (evict_line),
        .fill_valid         (fill_valid),
        .fill_line          (fill_line),
        .fill_addr          (fill_addr),
        .fill_err           (fill_err),
        .stray_resp         (stray_resp),
        .mem_req            (mem_req),
        .mem_store          (mem_store),
        .mem_address        (mem_address),
        .mem_evict_data     (mem_evict_data),
        .mem_fill_data      (mem_fill_data),
        .mem_response_valid (mem_response_valid)
    );

    always #5 clk = ~clk;

    // Memory model: word store on mem_req&mem_store, delayed line response on a fill read.
    logic [31:0]  mem [0:255];
    logic         init_done  = 1'b0;
    int           pend       = 0;
    logic [7:0]   rd_addr    = '0;
    logic         model_resp = 1'b0;
    logic         force_resp = 1'b0;
    logic         no_resp    = 1'b0;
    logic [127:0] model_data = '0;

    assign mem_response_valid = model_resp | force_resp;
    assign mem_fill_data      = model_data;

    always @(posedge clk) begin
        model_resp <= 1'b0;
        if (!init_done) begin
            for (int a = 0; a < 256; a++) mem[a] <= 32'(a) - 32'h3F;
            init_done <= 1'b1;
        end else if (mem_req && mem_store) begin
            mem[mem_address[7:0]] <= mem_evict_data;
        end
        if (pend > 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                model_resp <= 1'b1;
                model_data <= {mem[rd_addr + 8'd3], mem[rd_addr + 8'd2],
                               mem[rd_addr + 8'd1], mem[rd_addr]};
            end
        end
        if (mem_req && !mem_store && !no_resp) begin
            pend    <= MEM_DELAY - 1;
            rd_addr <= mem_address[7:0];
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic req);
        tests++;
        assert (obs === req) else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, req);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] req);
        tests++;
        assert (obs === req) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] req);
        tests++;
        assert (obs === req) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] exp_w [4];
    int          req_seen;

    initial begin
        exp_w[0] = 32'h0000AAAA;
        exp_w[1] = 32'h0000BBBB;
        exp_w[2] = 32'h0000CCCC;
        exp_w[3] = 32'h0000DDDD;

        reset_n     = 1'b0;
        miss_valid  = 1'b0;
        miss_addr   = '0;
        evict_valid = 1'b0;
        evict_addr  = '0;
        evict_line  = '0;
        repeat (3) @(negedge clk);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_store", mem_store, 1'b0);
        chk1("rst_fill_valid", fill_valid, 1'b0);
        chk1("rst_fill_err", fill_err, 1'b0);
        chk1("rst_stray", stray_resp, 1'b0);
        chk1("rst_miss_ready", miss_ready, 1'b1);
        chk32("rst_mem_address", mem_address, 32'h0);
        chk128("rst_fill_line", fill_line, 128'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Clean miss at 0x40
        miss_valid = 1'b1;
        miss_addr  = 32'h40;
        @(negedge clk);
        miss_valid = 1'b0;
        chk1("t1_c1_req", mem_req, 1'b1);
        chk1("t1_c1_store", mem_store, 1'b0);
        chk32("t1_c1_addr", mem_address, 32'h40);
        chk1("t1_c1_busy", miss_ready, 1'b0);
        @(negedge clk);
        chk1("t1_c2_req", mem_req, 1'b0);
        repeat (4) @(negedge clk);
        chk1("t1_c6_fill_valid", fill_valid, 1'b0);
        @(negedge clk);
        chk1("t1_c7_fill_valid", fill_valid, 1'b1);
        chk128("t1_fill_line", fill_line, 128'h00000004_00000003_00000002_00000001);
        chk32("t1_fill_addr", fill_addr, 32'h40);
        chk1("t1_fill_err", fill_err, 1'b0);
        @(negedge clk);
        chk1("t1_c8_ready", miss_ready, 1'b1);
        chk1("t1_c8_fill_valid", fill_valid, 1'b0);

        // Dirty miss: evict line 0x20, fill line 0x10
        miss_valid  = 1'b1;
        miss_addr   = 32'h13;
        evict_valid = 1'b1;
        evict_addr  = 32'h21;
        evict_line  = 128'h0000DDDD_0000CCCC_0000BBBB_0000AAAA;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            miss_valid  = 1'b0;
            evict_valid = 1'b0;
            chk1("t2_st_req", mem_req, 1'b1);
            chk1("t2_st_store", mem_store, 1'b1);
            chk32("t2_st_addr", mem_address, 32'h20 + 32'(k));
            chk32("t2_st_data", mem_evict_data, exp_w[k]);
        end
        @(negedge clk);
        chk1("t2_c5_req", mem_req, 1'b1);
        chk1("t2_c5_store", mem_store, 1'b0);
        chk32("t2_c5_addr", mem_address, 32'h10);
        repeat (5) @(negedge clk);
        chk1("t2_c10_fill_valid", fill_valid, 1'b0);
        @(negedge clk);
        chk1("t2_c11_fill_valid", fill_valid, 1'b1);
        chk32("t2_fill_addr", fill_addr, 32'h10);
        chk128("t2_fill_line", fill_line, 128'hFFFFFFD4_FFFFFFD3_FFFFFFD2_FFFFFFD1);
        @(negedge clk);

        // Same-line evict + miss at 0x08
        miss_valid  = 1'b1;
        miss_addr   = 32'h08;
        evict_valid = 1'b1;
        evict_addr  = 32'h08;
        evict_line  = 128'h89ABCDEF_01234567_DEADBEEF_CAFEF00D;
        @(negedge clk);
        miss_valid  = 1'b0;
        evict_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk1("t3_fill_valid", fill_valid, 1'b1);
        chk128("t3_fill_line", fill_line, 128'h89ABCDEF_01234567_DEADBEEF_CAFEF00D);
        chk1("t3_fill_err", fill_err, 1'b0);
        @(negedge clk);

        // Timeout: memory never answers
        no_resp    = 1'b1;
        miss_valid = 1'b1;
        miss_addr  = 32'h52;
        @(negedge clk);
        miss_valid = 1'b0;
        chk32("t4_c1_addr", mem_address, 32'h50);
        repeat (16) @(negedge clk);
        chk1("t4_c17_fill_valid", fill_valid, 1'b0);
        chk1("t4_c17_busy", miss_ready, 1'b0);
        @(negedge clk);
        chk1("t4_c18_fill_valid", fill_valid, 1'b1);
        chk1("t4_fill_err", fill_err, 1'b1);
        chk128("t4_fill_line", fill_line, 128'h0);
        chk32("t4_fill_addr", fill_addr, 32'h50);
        @(negedge clk);
        chk1("t4_c19_ready", miss_ready, 1'b1);
        chk1("t4_c19_fill_valid", fill_valid, 1'b0);
        chk1("t4_err_hold", fill_err, 1'b1);
        chk1("t4_no_stray", stray_resp, 1'b0);
        no_resp = 1'b0;

        // Reset during the second evict store
        miss_valid  = 1'b1;
        miss_addr   = 32'h30;
        evict_valid = 1'b1;
        evict_addr  = 32'h60;
        evict_line  = 128'h44444444_33333333_22222222_11111111;
        @(negedge clk);
        miss_valid  = 1'b0;
        evict_valid = 1'b0;
        chk32("t5_c1_addr", mem_address, 32'h60);
        @(negedge clk);
        chk1("t5_c2_req", mem_req, 1'b1);
        chk32("t5_c2_addr", mem_address, 32'h61);
        chk32("t5_c2_data", mem_evict_data, 32'h22222222);
        reset_n = 1'b0;
        #1;
        chk1("t5_rst_req", mem_req, 1'b0);
        chk1("t5_rst_store", mem_store, 1'b0);
        chk1("t5_rst_ready", miss_ready, 1'b1);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk1("t5_post_ready", miss_ready, 1'b1);
        chk1("t5_post_req", mem_req, 1'b0);
        chk1("t5_post_err", fill_err, 1'b0);
        chk128("t5_post_line", fill_line, 128'h0);
        chk1("t5_post_stray", stray_resp, 1'b0);
        repeat (3) @(negedge clk);
        chk1("t5_idle_req", mem_req, 1'b0);
        force_resp = 1'b1;
        @(negedge clk);
        force_resp = 1'b0;
        chk1("t5_stray_set", stray_resp, 1'b1);
        chk1("t5_stray_no_fill", fill_valid, 1'b0);
        @(negedge clk);
        chk1("t5_stray_sticky", stray_resp, 1'b1);
        chk1("t5_stray_no_fill2", fill_valid, 1'b0);

        // Back-to-back misses with miss_valid held high
        miss_valid  = 1'b1;
        miss_addr   = 32'h40;
        evict_valid = 1'b0;
        @(negedge clk);
        chk1("t6_c1_req", mem_req, 1'b1);
        chk32("t6_c1_addr", mem_address, 32'h40);
        req_seen = 0;
        for (int c = 2; c <= 6; c++) begin
            @(negedge clk);
            if (c == 3) miss_addr = 32'h44;
            if (mem_req) req_seen++;
        end
        @(negedge clk);
        if (mem_req) req_seen++;
        chk1("t6_c7_fill_valid", fill_valid, 1'b1);
        chk32("t6_c7_fill_addr", fill_addr, 32'h40);
        chk128("t6_c7_fill_line", fill_line, 128'h00000004_00000003_00000002_00000001);
        @(negedge clk);
        if (mem_req) req_seen++;
        chk1("t6_c8_ready", miss_ready, 1'b1);
        chk32("t6_no_extra_req", 32'(req_seen), 32'd0);
        @(negedge clk);
        miss_valid = 1'b0;
        chk1("t6_c9_req", mem_req, 1'b1);
        chk1("t6_c9_store", mem_store, 1'b0);
        chk32("t6_c9_addr", mem_address, 32'h44);
        chk1("t6_c9_busy", miss_ready, 1'b0);
        repeat (6) @(negedge clk);
        chk1("t6_c15_fill_valid", fill_valid, 1'b1);
        chk32("t6_c15_fill_addr", fill_addr, 32'h44);
        chk128("t6_c15_fill_line", fill_line, 128'h00000008_00000007_00000006_00000005);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mem_line_requester.md
Name: mem_line_requester

Overview:
- Initiator-side controller that drives the word-store / line-fill memory port on behalf of a cache.
- Accepts one line-miss transaction at a time, with an optional dirty-line eviction.
- Writes back the evicted line as sequential single-word stores, issues a one-cycle line-fill read, waits for the delayed response and returns the line to the cache.
- Sits between the cache miss logic and the memory block.

Parameters:
- FILL_DATA_WIDTH, 128, line width returned by memory.
- STORE_DATA_WIDTH, 32, word width of one memory store.
- ADDRESS_WIDTH, 32, word address width (memory address units are words).
- TIMEOUT, 16, maximum WAIT cycles before a fill is aborted; must exceed the memory transfer latency.
- Derived: WPL = FILL_DATA_WIDTH/STORE_DATA_WIDTH (4); OFS = $clog2(WPL) (2).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- miss_valid  in  1  cache requests a line fill.
- miss_ready  out  1  high only in IDLE; the transaction is accepted when miss_valid & miss_ready.
- miss_addr  in  ADDRESS_WIDTH  word address of the missing line; low OFS bits are ignored.
- evict_valid  in  1  sampled with the accepted miss; 1 means a dirty line must be written first.
- evict_addr  in  ADDRESS_WIDTH  word address of the victim line; low OFS bits are ignored.
- evict_line  in  FILL_DATA_WIDTH  victim data; word k occupies bits [32k+31:32k].
- fill_valid  out  1  one-cycle pulse; fill_line/fill_addr/fill_err are valid.
- fill_line  out  FILL_DATA_WIDTH  returned line.
- fill_addr  out  ADDRESS_WIDTH  line base address (low OFS bits 0).
- fill_err  out  1  with fill_valid: transaction timed out and fill_line is 0.
- stray_resp  out  1  sticky: mem_response_valid was seen outside WAIT.
- mem_req  out  1  memory request.
- mem_store  out  1  1 = store word, 0 = fill read.
- mem_address  out  ADDRESS_WIDTH  word address to memory.
- mem_evict_data  out  STORE_DATA_WIDTH  store data.
- mem_fill_data  in  FILL_DATA_WIDTH  memory read data.
- mem_response_valid  in  1  memory read data valid, single-cycle pulse.

Behaviour:
- Reset (async assert, any state):
  - State goes to IDLE.
  - mem_req, mem_store, fill_valid, fill_err and stray_resp are 0.
  - mem_address, mem_evict_data, fill_line, fill_addr, the word counter and the wait counter are 0.
  - Captured miss/evict addresses and data are cleared.
- Reset mid-transaction aborts with no further mem_req. A late memory response arriving after reset sets stray_resp; this is expected.
- All memory-side outputs and fill_* are registered.
- IDLE:
  - miss_ready=1, mem_req=0.
  - On acceptance, capture the line base addresses (low OFS bits zeroed), evict_line and evict_valid.
  - Next state is EVICT if evict_valid, else FILL_REQ.
- EVICT:
  - Exactly WPL consecutive cycles, k=0..WPL-1.
  - mem_req=1, mem_store=1, mem_address=evict_base+k, mem_evict_data=word k.
  - After k=WPL-1, go to FILL_REQ.
- FILL_REQ:
  - Exactly one cycle: mem_req=1, mem_store=0, mem_address=miss_base.
  - Then WAIT with the wait counter at 0.
- WAIT:
  - mem_req=0; the wait counter increments each cycle.
  - On mem_response_valid: capture mem_fill_data into fill_line, set fill_err=0, go to RESPOND.
  - If the counter reaches TIMEOUT without a response: fill_line=0, fill_err=1, go to RESPOND.
- RESPOND:
  - Exactly one cycle: fill_valid=1, fill_addr=miss_base. Then IDLE.
  - fill_line, fill_addr and fill_err hold until the next RESPOND.
- Request timing: mem_req is never high in two consecutive cycles with mem_store=0. Exactly one fill read is issued per transaction.
- mem_response_valid in IDLE, EVICT, FILL_REQ or RESPOND is ignored for data and sets stray_resp, which clears only on reset.
- A response and a timeout in the same cycle: the response wins (fill_err=0).
- Evict and miss to the same line are legal: the stores complete before the fill read, so the fill returns the freshly written data.
- Latency, memory delay D, acceptance in cycle 0:
  - Without evict: FILL_REQ in cycle 1, response in cycle 1+D, fill_valid in cycle 2+D, miss_ready again in cycle 3+D.
  - With evict: add WPL cycles.
- miss_valid while busy is not accepted. miss_* and evict_* inputs are ignored outside IDLE.

Test Plan (memory delay D=5, default parameters):
- Clean miss at 0x40 after reset; memory pre-loaded with words 0x40..0x43 = 1,2,3,4 → mem_req/store=0 at addr 0x40 in cycle 1; fill_valid in cycle 7 with fill_line=0x00000004_00000003_00000002_00000001, fill_addr=0x40, fill_err=0.
- Dirty miss: miss_addr=0x13, evict_addr=0x21, evict_line=0xDDDD_CCCC_BBBB_AAAA (word3..word0, 32b each) → stores to 0x20,0x21,0x22,0x23 carry AAAA,BBBB,CCCC,DDDD in cycles 1-4; fill read at 0x10 in cycle 5; fill_valid in cycle 11.
- Same-line evict+miss at 0x08 → fill_line equals evict_line; fill_err=0.
- Memory model never responds → fill_valid with fill_err=1, fill_line=0 exactly TIMEOUT cycles after entering WAIT; miss_ready=1 the following cycle.
- Assert reset_n=0 during the second EVICT cycle → mem_req=0 immediately; IDLE and miss_ready=1 after release. A forced response pulse in IDLE sets stray_resp=1 and leaves fill_valid=0.
- Hold miss_valid high for back-to-back misses → second acceptance occurs in the cycle after fill_valid; no overlapping mem_req.
